// File: rtl/id_ex_pipelined_decode.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipelined_decode
// Purpose  : Decode stage with bypassed register bank, load-use hazard stall
//            and a flushable/holdable ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module id_ex_pipelined_decode #(
    parameter int NB_INST   = 32,
    parameter int NB_PC     = 32,
    parameter int NB_DATA   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_OPCODE = 6
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic [NB_INST-1:0]   i_inst,
    input  logic [NB_PC-1:0]     i_pc,
    input  logic                 i_wb_reg_write,
    input  logic [NB_REG-1:0]    i_wb_write_reg,
    input  logic [NB_DATA-1:0]   i_wb_write_data,
    output logic                 o_stall,
    output logic                 o_jump,
    output logic [NB_PC-1:0]     o_jump_address,
    output logic                 o_valid,
    output logic                 o_reg_dest,
    output logic                 o_alu_src,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_branch,
    output logic                 o_reg_write,
    output logic                 o_mem_to_reg,
    output logic                 o_byte_en,
    output logic                 o_halfword_en,
    output logic                 o_word_en,
    output logic [NB_OPCODE-1:0] o_alu_op,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic [NB_DATA-1:0]   o_immediate,
    output logic [NB_DATA-1:0]   o_shamt,
    output logic [NB_REG-1:0]    o_rs,
    output logic [NB_REG-1:0]    o_rt,
    output logic [NB_REG-1:0]    o_rd,
    output logic [NB_PC-1:0]     o_pc
);

    localparam int c_N_REGS = 2 ** NB_REG;

    localparam logic [NB_OPCODE-1:0] c_OP_R    = 6'b000000;
    localparam logic [NB_OPCODE-1:0] c_OP_LW   = 6'b100011;
    localparam logic [NB_OPCODE-1:0] c_OP_LH   = 6'b100001;
    localparam logic [NB_OPCODE-1:0] c_OP_LB   = 6'b100000;
    localparam logic [NB_OPCODE-1:0] c_OP_SW   = 6'b101011;
    localparam logic [NB_OPCODE-1:0] c_OP_SH   = 6'b101001;
    localparam logic [NB_OPCODE-1:0] c_OP_SB   = 6'b101000;
    localparam logic [NB_OPCODE-1:0] c_OP_BEQ  = 6'b000100;
    localparam logic [NB_OPCODE-1:0] c_OP_BNE  = 6'b000101;
    localparam logic [NB_OPCODE-1:0] c_OP_ADDI = 6'b001000;
    localparam logic [NB_OPCODE-1:0] c_OP_J    = 6'b000010;
    localparam logic [NB_OPCODE-1:0] c_OP_JAL  = 6'b000011;

    typedef struct packed {
        logic                 valid;
        logic                 reg_dest;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 byte_en;
        logic                 halfword_en;
        logic                 word_en;
        logic [NB_OPCODE-1:0] alu_op;
        logic [NB_DATA-1:0]   data_a;
        logic [NB_DATA-1:0]   data_b;
        logic [NB_DATA-1:0]   immediate;
        logic [NB_DATA-1:0]   shamt;
        logic [NB_REG-1:0]    rs;
        logic [NB_REG-1:0]    rt;
        logic [NB_REG-1:0]    rd;
        logic [NB_PC-1:0]     pc;
    } idex_t;

    logic [NB_DATA-1:0]   r_bank [c_N_REGS];
    idex_t                r_idex;
    idex_t                w_dec;
    logic                 w_is_jump;
    logic                 w_stall;
    logic [NB_OPCODE-1:0] w_opcode;
    logic [NB_REG-1:0]    w_rs;
    logic [NB_REG-1:0]    w_rt;
    logic [NB_REG-1:0]    w_rd;
    logic [NB_DATA-1:0]   w_read_a;
    logic [NB_DATA-1:0]   w_read_b;

    assign w_opcode = i_inst[NB_INST-1 -: NB_OPCODE];
    assign w_rs     = i_inst[21 +: NB_REG];
    assign w_rt     = i_inst[16 +: NB_REG];
    assign w_rd     = i_inst[11 +: NB_REG];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < c_N_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_wb_reg_write && (i_wb_write_reg != '0)) begin
            r_bank[i_wb_write_reg] <= i_wb_write_data;
        end
    end

    // Write-through bypass so the ID/EX capture never sees the pre-write value
    always_comb begin
        w_read_a = r_bank[w_rs];
        w_read_b = r_bank[w_rt];
        if (i_wb_reg_write && (i_wb_write_reg == w_rs)) begin
            w_read_a = i_wb_write_data;
        end
        if (i_wb_reg_write && (i_wb_write_reg == w_rt)) begin
            w_read_b = i_wb_write_data;
        end
        if (w_rs == '0) begin
            w_read_a = '0;
        end
        if (w_rt == '0) begin
            w_read_b = '0;
        end
    end

    always_comb begin
        w_dec           = '0;
        w_is_jump       = 1'b0;
        w_dec.valid     = 1'b1;
        w_dec.alu_op    = w_opcode;
        w_dec.data_a    = w_read_a;
        w_dec.data_b    = w_read_b;
        w_dec.immediate = {{(NB_DATA-16){i_inst[15]}}, i_inst[15:0]};
        w_dec.shamt     = {{(NB_DATA-5){1'b0}}, i_inst[10:6]};
        w_dec.rs        = w_rs;
        w_dec.rt        = w_rt;
        w_dec.rd        = w_rd;
        w_dec.pc        = i_pc;
        case (w_opcode)
            c_OP_R: begin
                w_dec.reg_dest  = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.word_en   = 1'b1;
            end
            c_OP_LW, c_OP_LH, c_OP_LB: begin
                w_dec.alu_src     = 1'b1;
                w_dec.mem_read    = 1'b1;
                w_dec.mem_to_reg  = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.word_en     = (w_opcode == c_OP_LW);
                w_dec.halfword_en = (w_opcode == c_OP_LH);
                w_dec.byte_en     = (w_opcode == c_OP_LB);
            end
            c_OP_SW, c_OP_SH, c_OP_SB: begin
                w_dec.alu_src     = 1'b1;
                w_dec.mem_write   = 1'b1;
                w_dec.word_en     = (w_opcode == c_OP_SW);
                w_dec.halfword_en = (w_opcode == c_OP_SH);
                w_dec.byte_en     = (w_opcode == c_OP_SB);
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_dec.branch = 1'b1;
            end
            c_OP_ADDI: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            c_OP_J: begin
                w_is_jump = 1'b1;
            end
            c_OP_JAL: begin
                w_is_jump       = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Load in EX whose destination feeds this instruction; a flush kills the pair anyway
    assign w_stall = r_idex.valid && r_idex.mem_read && (r_idex.rt != '0) &&
                     ((r_idex.rt == w_rs) || (r_idex.rt == w_rt)) && !i_flush;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_idex <= '0;
        end else if (i_flush) begin
            r_idex <= '0;
        end else if (!i_enable) begin
            r_idex <= r_idex;
        end else if (w_stall) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_dec;
        end
    end

    assign o_stall        = w_stall;
    assign o_jump         = w_is_jump && !w_stall && !i_flush;
    assign o_jump_address = {i_pc[NB_PC-1 -: 4], i_inst[25:0], 2'b00};
    assign o_valid        = r_idex.valid;
    assign o_reg_dest     = r_idex.reg_dest;
    assign o_alu_src      = r_idex.alu_src;
    assign o_mem_read     = r_idex.mem_read;
    assign o_mem_write    = r_idex.mem_write;
    assign o_branch       = r_idex.branch;
    assign o_reg_write    = r_idex.reg_write;
    assign o_mem_to_reg   = r_idex.mem_to_reg;
    assign o_byte_en      = r_idex.byte_en;
    assign o_halfword_en  = r_idex.halfword_en;
    assign o_word_en      = r_idex.word_en;
    assign o_alu_op       = r_idex.alu_op;
    assign o_data_a       = r_idex.data_a;
    assign o_data_b       = r_idex.data_b;
    assign o_immediate    = r_idex.immediate;
    assign o_shamt        = r_idex.shamt;
    assign o_rs           = r_idex.rs;
    assign o_rt           = r_idex.rt;
    assign o_rd           = r_idex.rd;
    assign o_pc           = r_idex.pc;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipelined_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipelined_decode
// Purpose  : Directed bench for id_ex_pipelined_decode with a reference model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_pipelined_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        stall, jump, valid;
    logic [31:0] jump_address;
    logic        reg_dest, alu_src, mem_read, mem_write, branch, reg_write, mem_to_reg;
    logic        byte_en, halfword_en, word_en;
    logic [5:0]  alu_op;
    logic [31:0] data_a, data_b, immediate, shamt, pc_out;
    logic [4:0]  rs, rt, rd;

    int n_chk = 0;
    int n_err = 0;

    id_ex_pipelined_decode dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_enable       (enable),
        .i_flush        (flush),
        .i_inst         (inst),
        .i_pc           (pc),
        .i_wb_reg_write (wb_we),
        .i_wb_write_reg (wb_addr),
        .i_wb_write_data(wb_data),
        .o_stall        (stall),
        .o_jump         (jump),
        .o_jump_address (jump_address),
        .o_valid        (valid),
        .o_reg_dest     (reg_dest),
        .o_alu_src      (alu_src),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_branch       (branch),
        .o_reg_write    (reg_write),
        .o_mem_to_reg   (mem_to_reg),
        .o_byte_en      (byte_en),
        .o_halfword_en  (halfword_en),
        .o_word_en      (word_en),
        .o_alu_op       (alu_op),
        .o_data_a       (data_a),
        .o_data_b       (data_b),
        .o_immediate    (immediate),
        .o_shamt        (shamt),
        .o_rs           (rs),
        .o_rt           (rt),
        .o_rd           (rd),
        .o_pc           (pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control flags per opcode: {reg_dest,alu_src,mem_read,mem_write,branch,reg_write,mem_to_reg,byte,half,word}
    localparam logic [9:0] RD = 10'b1000000000, AS = 10'b0100000000, MR = 10'b0010000000;
    localparam logic [9:0] MW = 10'b0001000000, BR = 10'b0000100000, RW = 10'b0000010000;
    localparam logic [9:0] MT = 10'b0000001000, BY = 10'b0000000100, HW = 10'b0000000010;
    localparam logic [9:0] WD = 10'b0000000001;

    logic [9:0] ctrl_tab [64];
    logic       jump_tab [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            ctrl_tab[i] = '0;
            jump_tab[i] = 1'b0;
        end
        ctrl_tab[6'o00] = RD | RW | WD;
        ctrl_tab[35]    = AS | MR | MT | RW | WD;
        ctrl_tab[33]    = AS | MR | MT | RW | HW;
        ctrl_tab[32]    = AS | MR | MT | RW | BY;
        ctrl_tab[43]    = AS | MW | WD;
        ctrl_tab[41]    = AS | MW | HW;
        ctrl_tab[40]    = AS | MW | BY;
        ctrl_tab[4]     = BR;
        ctrl_tab[5]     = BR;
        ctrl_tab[8]     = AS | RW;
        ctrl_tab[3]     = RW;
        jump_tab[2]     = 1'b1;
        jump_tab[3]     = 1'b1;
    end

    typedef struct packed {
        logic        valid;
        logic [9:0]  ctrl;
        logic [5:0]  op;
        logic [31:0] a, b, imm, sh;
        logic [4:0]  rs, rt, rd;
        logic [31:0] pc;
    } stage_t;

    stage_t      m_cur = '0;
    stage_t      m_nxt = '0;
    logic [31:0] m_regs [32];
    logic        m_wr = 1'b0;

    initial for (int i = 0; i < 32; i++) m_regs[i] = '0;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    // Compare process: outputs are settled at the falling edge
    always @(negedge clk) begin
        stage_t      exp_s;
        stage_t      dec;
        logic        exp_stall, exp_jump;
        logic [4:0]  f_rs, f_rt;
        f_rs  = inst[25:21];
        f_rt  = inst[20:16];
        exp_s = rst_n ? m_cur : '0;
        exp_stall = rst_n && exp_s.valid && exp_s.ctrl[7] && exp_s.rt != 0 &&
                    (exp_s.rt == f_rs || exp_s.rt == f_rt) && !flush;
        exp_jump  = jump_tab[inst[31:26]] && !exp_stall && !flush;

        chk("stall", 64'(stall), 64'(exp_stall));
        chk("jump", 64'(jump), 64'(exp_jump));
        chk("jump_address", 64'(jump_address), 64'({pc[31:28], inst[25:0], 2'b00}));
        chk("valid", 64'(valid), 64'(exp_s.valid));
        chk("controls", 64'({reg_dest, alu_src, mem_read, mem_write, branch, reg_write,
                             mem_to_reg, byte_en, halfword_en, word_en}), 64'(exp_s.ctrl));
        chk("alu_op", 64'(alu_op), 64'(exp_s.op));
        chk("operands", {data_a, data_b}, {exp_s.a, exp_s.b});
        chk("imm_shamt", {immediate, shamt}, {exp_s.imm, exp_s.sh});
        chk("fields_pc", 64'({rs, rt, rd, pc_out}), 64'({exp_s.rs, exp_s.rt, exp_s.rd, exp_s.pc}));

        dec.valid = 1'b1;
        dec.ctrl  = ctrl_tab[inst[31:26]];
        dec.op    = inst[31:26];
        dec.a     = m_read(f_rs);
        dec.b     = m_read(f_rt);
        dec.imm   = 32'($signed(inst[15:0]));
        dec.sh    = 32'(inst[10:6]);
        dec.rs    = f_rs;
        dec.rt    = f_rt;
        dec.rd    = inst[15:11];
        dec.pc    = pc;

        if (!rst_n)           m_nxt = '0;
        else if (flush)       m_nxt = '0;
        else if (!enable)     m_nxt = exp_s;
        else if (exp_stall)   m_nxt = '0;
        else                  m_nxt = dec;
        m_wr = rst_n && wb_we && wb_addr != 0;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cur <= '0;
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
        end else begin
            m_cur <= m_nxt;
            if (m_wr) m_regs[wb_addr] <= wb_data;
        end
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic fl,
                         input logic en, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        inst = i; pc = p; flush = fl; enable = en; wb_we = we; wb_addr = wa; wb_data = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD_6_5_5  = 32'h00A53020;
    localparam logic [31:0] ADD_1_3_3  = 32'h00630820;
    localparam logic [31:0] LW_2_4_0   = 32'h8C020004;
    localparam logic [31:0] ADD_4_2_5  = 32'h00452020;
    localparam logic [31:0] LW_0_0_0   = 32'h8C000000;
    localparam logic [31:0] ADD_4_0_0  = 32'h00002020;
    localparam logic [31:0] SB_7_M1_8  = 32'hA107FFFF;
    localparam logic [31:0] ADDI_9_1   = 32'h20298000;
    localparam logic [31:0] J_10       = 32'h08000010;

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        repeat (3) tick();
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_ctrl", 64'({reg_write, mem_read, alu_op}), 64'd0);
        chk("reset_data", {data_a, pc_out}, 64'd0);

        rst_n = 1'b1;
        drive(ADD_6_5_5, 32'h4, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk("r5_after_reset", 64'(data_a), 64'd0);
        chk("add_valid_rd", 64'({valid, reg_dest, rd}), 64'({1'b1, 1'b1, 5'd6}));

        drive(ADD_1_3_3, 32'h8, 1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        chk("bypass_ab", {data_a, data_b}, {32'hDEADBEEF, 32'hDEADBEEF});
        drive(ADD_1_3_3, 32'hC, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk("bank_r3", 64'(data_a), 64'h0DEADBEEF);

        drive(LW_2_4_0, 32'h10, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        drive(ADD_4_2_5, 32'h14, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("loaduse_stall", 64'(stall), 64'd1);
        tick();
        chk("loaduse_bubble", 64'(valid), 64'd0);
        chk("loaduse_one_cycle", 64'(stall), 64'd0);
        tick();
        chk("loaduse_add", 64'({valid, rs, rt}), 64'({1'b1, 5'd2, 5'd5}));

        drive(LW_0_0_0, 32'h18, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        drive(ADD_4_0_0, 32'h1C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("r0_no_stall", 64'(stall), 64'd0);
        tick();
        drive(ADD_4_0_0, 32'h20, 1'b0, 1'b1, 1'b1, 5'd0, 32'h1234);
        tick();
        chk("r0_reads_zero", {data_a, data_b}, 64'd0);

        drive(LW_2_4_0, 32'h24, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        drive(ADD_4_2_5, 32'h28, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("flush_no_stall", 64'(stall), 64'd0);
        tick();
        chk("flush_bubble", 64'({valid, reg_write}), 64'd0);

        drive(SB_7_M1_8, 32'h2C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk("sb_decode", 64'({alu_op, mem_write, byte_en, immediate}), 64'({6'h28, 1'b1, 1'b1, 32'hFFFFFFFF}));
        drive(ADDI_9_1, 32'h30, 1'b0, 1'b0, 1'b1, 5'd5, 32'h55);
        tick();
        drive(ADDI_9_1, 32'h30, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("hold_frozen", 64'({valid, alu_op, pc_out}), 64'({1'b1, 6'h28, 32'h2C}));
        drive(ADD_6_5_5, 32'h34, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk("hold_bank_write", 64'(data_a), 64'h55);

        drive(J_10, 32'h40000004, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("jump_taken", 64'({jump, jump_address}), 64'({1'b1, 32'h40000040}));
        tick();
        drive(J_10, 32'h40000004, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("jump_flushed", 64'(jump), 64'd0);
        tick();

        drive(32'h10220003, 32'h44, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        drive(32'hFC000000, 32'h48, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        chk("unknown_nop", 64'({valid, reg_write, mem_read, branch, word_en}), 64'({1'b1, 4'b0000}));
        drive(32'h84A30002, 32'h4C, 1'b0, 1'b1, 1'b1, 5'd5, 32'hA5A5A5A5); tick();
        drive(32'h0C000004, 32'h50, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        drive(32'h20298000, 32'h54, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        drive(32'hAD230008, 32'h58, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        drive(32'h14A50001, 32'h5C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        drive(32'h00853140, 32'h60, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();

        drive(LW_2_4_0, 32'h64, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        drive(ADD_4_2_5, 32'h68, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("midstall_stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midstall_reset", 64'({stall, valid}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        drive(ADD_6_5_5, 32'h6C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk("post_reset_r5", 64'({valid, data_a}), 64'({1'b1, 32'h0}));
        tick();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
